// File: rtl/watermark_compositor.sv
// Two-stage pixel compositor: selects or combines the image, watermark and register-output sources per pixel.
// Optional build macro WM_SAT_COUNT_EN adds sat_cnt, a count of mode-6 beats in which any channel clamped.
module watermark_compositor #(
    parameter int CH_W    = 4,
    parameter int NUM_CH  = 3,
    parameter int IDX_W   = 12,
    parameter int ALPHA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CH_W-1:0]   image_pix,
    input  logic [NUM_CH*CH_W-1:0]   water_pix,
    input  logic [NUM_CH*CH_W-1:0]   regout_pix,
    input  logic [IDX_W-1:0]         in_index,
    input  logic                     in_hs,
    input  logic                     in_vs,
    input  logic [2:0]               mode,
    input  logic [ALPHA_W-1:0]       alpha,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   out_pix,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_hs,
    output logic                     out_vs,
`ifdef WM_SAT_COUNT_EN
    output logic [15:0]              sat_cnt,
`endif
    output logic [15:0]              frame_cnt
);

    localparam int PIX_W = NUM_CH * CH_W;
    localparam int BL_W  = CH_W + ALPHA_W + 1;

    localparam logic [2:0] MODE_IMAGE  = 3'd0;
    localparam logic [2:0] MODE_WATER  = 3'd1;
    localparam logic [2:0] MODE_REGOUT = 3'd2;
    localparam logic [2:0] MODE_XOR    = 3'd3;
    localparam logic [2:0] MODE_BLEND  = 3'd4;
    localparam logic [2:0] MODE_EMBED  = 3'd5;
    localparam logic [2:0] MODE_SATADD = 3'd6;

    localparam logic [CH_W-1:0]    CH_MAX    = {CH_W{1'b1}};
    localparam logic [ALPHA_W:0]   ALPHA_ONE = {1'b1, {ALPHA_W{1'b0}}};

    logic [2:0]         mode_reg;
    logic [ALPHA_W-1:0] alpha_reg;

    logic               s1_valid_reg;
    logic [PIX_W-1:0]   s1_image_reg;
    logic [PIX_W-1:0]   s1_water_reg;
    logic [PIX_W-1:0]   s1_regout_reg;
    logic [IDX_W-1:0]   s1_index_reg;
    logic               s1_hs_reg;
    logic               s1_vs_reg;
    logic [2:0]         s1_mode_reg;
    logic [ALPHA_W-1:0] s1_alpha_reg;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;
    logic               frame_start;
    logic [2:0]         mode_next;
    logic [ALPHA_W-1:0] alpha_next;
    logic [PIX_W-1:0]   comp_pix;

    assign s2_adv      = !out_valid || out_ready;
    assign s1_adv      = s1_valid_reg && s2_adv;
    assign in_ready    = !s1_valid_reg || s1_adv;
    assign accept      = in_valid && in_ready;
    assign frame_start = accept && (in_index == '0);

    // The index-0 beat itself already uses the newly requested mode and alpha.
    assign mode_next  = (in_index == '0) ? mode  : mode_reg;
    assign alpha_next = (in_index == '0) ? alpha : alpha_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg  <= MODE_IMAGE;
            alpha_reg <= '0;
            frame_cnt <= '0;
        end else if (frame_start) begin
            mode_reg  <= mode;
            alpha_reg <= alpha;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_image_reg  <= '0;
            s1_water_reg  <= '0;
            s1_regout_reg <= '0;
            s1_index_reg  <= '0;
            s1_hs_reg     <= 1'b1;
            s1_vs_reg     <= 1'b1;
            s1_mode_reg   <= MODE_IMAGE;
            s1_alpha_reg  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (accept) begin
                s1_image_reg  <= image_pix;
                s1_water_reg  <= water_pix;
                s1_regout_reg <= regout_pix;
                s1_index_reg  <= in_index;
                s1_hs_reg     <= in_hs;
                s1_vs_reg     <= in_vs;
                s1_mode_reg   <= mode_next;
                s1_alpha_reg  <= alpha_next;
            end
        end
    end

`ifdef WM_SAT_COUNT_EN
    logic [NUM_CH-1:0] clamp_vec;
    logic              out_sat_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CH_W-1:0] ch_i;
            logic [CH_W-1:0] ch_w;
            logic [CH_W-1:0] ch_r;
            logic [BL_W-1:0] blend_sum;
            logic [CH_W-1:0] blend_ch;
            logic [CH_W:0]   add_sum;
            logic [CH_W-1:0] sat_ch;
            logic [CH_W-1:0] res_ch;

            assign ch_i = s1_image_reg[gi*CH_W +: CH_W];
            assign ch_w = s1_water_reg[gi*CH_W +: CH_W];
            assign ch_r = s1_regout_reg[gi*CH_W +: CH_W];

            // Weights sum to 2^ALPHA_W, so the shift renormalises the blend.
            assign blend_sum = {{(ALPHA_W+1){1'b0}}, ch_i} * {{CH_W{1'b0}}, ALPHA_ONE - {1'b0, s1_alpha_reg}}
                             + {{(ALPHA_W+1){1'b0}}, ch_w} * {{(CH_W+1){1'b0}}, s1_alpha_reg};
            assign blend_ch  = CH_W'(blend_sum >> ALPHA_W);

            assign add_sum = {1'b0, ch_i} + {1'b0, ch_w};
            assign sat_ch  = add_sum[CH_W] ? CH_MAX : add_sum[CH_W-1:0];

            always_comb begin
                res_ch = ch_i;
                case (s1_mode_reg)
                    MODE_IMAGE:  res_ch = ch_i;
                    MODE_WATER:  res_ch = ch_w;
                    MODE_REGOUT: res_ch = ch_r;
                    MODE_XOR:    res_ch = ch_i ^ ch_w;
                    MODE_BLEND:  res_ch = blend_ch;
                    MODE_EMBED:  res_ch = {ch_i[CH_W-1:1], ch_w[CH_W-1]};
                    MODE_SATADD: res_ch = sat_ch;
                    default:     res_ch = ch_i;
                endcase
            end

            assign comp_pix[gi*CH_W +: CH_W] = res_ch;
`ifdef WM_SAT_COUNT_EN
            assign clamp_vec[gi] = add_sum[CH_W];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_index <= '0;
            out_hs    <= 1'b1;
            out_vs    <= 1'b1;
        end else if (s2_adv) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_pix   <= comp_pix;
                out_index <= s1_index_reg;
                out_hs    <= s1_hs_reg;
                out_vs    <= s1_vs_reg;
            end
        end
    end

`ifdef WM_SAT_COUNT_EN
    // The clamp flag rides with the S2 beat so it is counted when that beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat_reg <= 1'b0;
            sat_cnt     <= '0;
        end else begin
            if (s1_adv) begin
                out_sat_reg <= (s1_mode_reg == MODE_SATADD) && (|clamp_vec);
            end
            if (out_valid && out_ready && out_sat_reg) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_watermark_compositor.sv
// Directed bench with a scoreboard queue of expected output beats, checked by immediate assertions.
module tb_watermark_compositor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] image_pix;
    logic [11:0] water_pix;
    logic [11:0] regout_pix;
    logic [11:0] in_index;
    logic        in_hs;
    logic        in_vs;
    logic [2:0]  mode;
    logic [3:0]  alpha;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pix;
    logic [11:0] out_index;
    logic        out_hs;
    logic        out_vs;
    logic [15:0] frame_cnt;
`ifdef WM_SAT_COUNT_EN
    logic [15:0] sat_cnt;
`endif

    watermark_compositor #(.CH_W(4), .NUM_CH(3), .IDX_W(12), .ALPHA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .image_pix(image_pix), .water_pix(water_pix), .regout_pix(regout_pix),
        .in_index(in_index), .in_hs(in_hs), .in_vs(in_vs),
        .mode(mode), .alpha(alpha),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_index(out_index), .out_hs(out_hs), .out_vs(out_vs),
`ifdef WM_SAT_COUNT_EN
        .sat_cnt(sat_cnt),
`endif
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pix;
        logic [11:0] idx;
        logic        hs;
        logic        vs;
        logic        sat;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;
    int   sat_exp = 0;
    int   acc_cnt = 0;
    bit   verbose = 1'b1;
    logic [2:0] tb_mode = 3'd0;
    logic [3:0] tb_alpha = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] model_pix(input logic [2:0] md, input logic [3:0] al,
                                              input logic [11:0] i, input logic [11:0] w,
                                              input logic [11:0] r);
        logic [11:0] res = '0;
        for (int c = 0; c < 3; c++) begin
            int ic = int'((i >> (4*c)) & 12'hF);
            int wc = int'((w >> (4*c)) & 12'hF);
            int rc = int'((r >> (4*c)) & 12'hF);
            int v;
            case (md)
                3'd1: v = wc;
                3'd2: v = rc;
                3'd3: v = ic ^ wc;
                3'd4: v = (ic * (16 - int'(al)) + wc * int'(al)) / 16;
                3'd5: v = (ic & 14) | (wc / 8);
                3'd6: v = (ic + wc > 15) ? 15 : ic + wc;
                default: v = ic;
            endcase
            res = res | (12'(v & 15) << (4*c));
        end
        return res;
    endfunction

    function automatic logic model_sat(input logic [2:0] md, input logic [11:0] i, input logic [11:0] w);
        logic s = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (int'((i >> (4*c)) & 12'hF) + int'((w >> (4*c)) & 12'hF) > 15) s = 1'b1;
        end
        return s && (md == 3'd6);
    endfunction

    task automatic send(input logic [11:0] img, input logic [11:0] wat, input logic [11:0] rgo,
                        input logic [11:0] idx, input logic [2:0] md, input logic [3:0] al);
        int budget = 0;
        exp_t e;
        @(negedge clk);
        image_pix  = img;
        water_pix  = wat;
        regout_pix = rgo;
        in_index   = idx;
        in_hs      = idx[0];
        in_vs      = (idx == 12'd0);
        mode       = md;
        alpha      = al;
        in_valid   = 1'b1;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (idx == 12'd0) begin
            tb_mode  = md;
            tb_alpha = al;
        end
        e.pix = model_pix(tb_mode, tb_alpha, img, wat, rgo);
        e.idx = idx;
        e.hs  = idx[0];
        e.vs  = (idx == 12'd0);
        e.sat = model_sat(tb_mode, img, wat);
        sb_q.push_back(e);
        acc_cnt++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (sb_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (verbose) $display("beat idx=%0d pix=0x%03h expected=0x%03h", out_index, out_pix, e.pix);
                chk("out_pix", 32'(out_pix), 32'(e.pix));
                chk("out_index", 32'(out_index), 32'(e.idx));
                chk("out_hs", 32'(out_hs), 32'(e.hs));
                chk("out_vs", 32'(out_vs), 32'(e.vs));
                if (e.sat) sat_exp++;
            end
        end
    end

    initial begin
        logic [11:0] cap_pix;
        int acc0;
        logic [15:0] f0;

        // Reset with random inputs
        rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        image_pix = '0; water_pix = '0; regout_pix = '0;
        in_index = '0; in_hs = 1'b0; in_vs = 1'b0; mode = '0; alpha = '0;
        repeat (4) begin
            @(posedge clk);
            #1;
            in_valid   = 1'($urandom);
            image_pix  = 12'($urandom);
            water_pix  = 12'($urandom);
            regout_pix = 12'($urandom);
            in_index   = 12'($urandom);
            mode       = 3'($urandom);
            alpha      = 4'($urandom);
        end
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_hs", 32'(out_hs), 32'd1);
        chk("rst_out_vs", 32'(out_vs), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // First beat: watermark passthrough, check pipeline latency
        send(12'h456, 12'h123, 12'h789, 12'd0, 3'd1, 4'd0);
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_pix", 32'(out_pix), 32'h123);
        drain();

        // Alpha blend, LSB embed, saturating add
        send(12'hF00, 12'h0F0, 12'h000, 12'd0, 3'd4, 4'd8);
        send(12'hF00, 12'h0F0, 12'h000, 12'd0, 3'd4, 4'd0);
        send(12'h888, 12'h80F, 12'h000, 12'd0, 3'd5, 4'd0);
        send(12'h9A3, 12'h805, 12'h000, 12'd0, 3'd6, 4'd0);
        send(12'h5A3, 12'h3C7, 12'hABC, 12'd0, 3'd2, 4'd3);
        send(12'h5A3, 12'h3C7, 12'hABC, 12'd0, 3'd7, 4'd3);
        drain();
`ifdef WM_SAT_COUNT_EN
        chk("sat_cnt", 32'(sat_cnt), 32'(sat_exp));
`endif

        // Backpressure: stall the output for four cycles while streaming six beats
        @(posedge clk);
        #1 out_ready = 1'b0;
        acc0 = acc_cnt;
        cap_pix = '0;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(12'($urandom), 12'($urandom), 12'($urandom), 12'(k), 3'd3, 4'd0);
            end
            begin
                repeat (3) @(negedge clk);
                cap_pix = out_pix;
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(acc_cnt - acc0), 32'd2);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_stable_pix", 32'(out_pix), 32'(cap_pix));
                chk("bp_head_pix", 32'(out_pix), 32'(sb_q[0].pix));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_accepted", 32'(acc_cnt - acc0), 32'd6);

        // Mode latching: a mid-frame mode change waits for the next index-0 beat
        f0 = frame_cnt;
        for (int k = 0; k < 8; k++) begin
            send(12'($urandom), 12'($urandom), 12'($urandom), 12'(k), (k >= 5) ? 3'd1 : 3'd0, 4'd0);
            if (k == 0) chk("frame_cnt_first", 32'(frame_cnt), 32'(f0 + 16'd1));
        end
        send(12'h321, 12'hABC, 12'h000, 12'd0, 3'd1, 4'd0);
        drain();
        chk("frame_cnt_second", 32'(frame_cnt), 32'(f0 + 16'd2));

        // Asynchronous reset with two beats in flight
        send(12'h111, 12'h222, 12'h333, 12'd0, 3'd2, 4'd0);
        send(12'h444, 12'h555, 12'h666, 12'd1, 3'd2, 4'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        sb_q.delete();
        tb_mode = 3'd0;
        tb_alpha = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(12'h9E1, 12'h17B, 12'h4D2, 12'd5, 3'd3, 4'd0);
        drain();

        // Frame counter wrap
        verbose = 1'b0;
        for (int k = 0; k < 65535; k++)
            send(12'(k), 12'h0, 12'h0, 12'd0, 3'd0, 4'd0);
        drain();
        chk("frame_cnt_max", 32'(frame_cnt), 32'h0000FFFF);
        send(12'h0, 12'h0, 12'h0, 12'd0, 3'd0, 4'd0);
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/watermark_compositor.md
Name: watermark_compositor

Overview:
- Parametrised, pipelined pixel compositor between the soft-processor pixel sources (image, watermark, register-output) and the VGA output path.
- Per pixel, selects or combines the three sources under one of eight modes, including alpha blend, LSB embed and saturating add.
- Carries index and HS/VS alongside each pixel, honours valid/ready backpressure, and counts frames.

Parameters:
- CH_W, 4, bits per colour channel
- NUM_CH, 3, colour channels per pixel; pixel width PIX_W = NUM_CH*CH_W, channel 0 in LSBs
- IDX_W, 12, pixel index width
- ALPHA_W, 4, blend coefficient width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  compositor can accept a beat
- image_pix  in  PIX_W  image source pixel
- water_pix  in  PIX_W  watermark source pixel
- regout_pix  in  PIX_W  processor register-output pixel
- in_index  in  IDX_W  pixel index; 0 marks the first pixel of a frame
- in_hs, in_vs  in  1 each  sync bits travelling with the pixel
- mode  in  3  composite mode request
- alpha  in  ALPHA_W  blend weight toward the watermark
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_pix  out  PIX_W  composited pixel
- out_index  out  IDX_W  index delayed with the pixel
- out_hs, out_vs  out  1 each  syncs delayed with the pixel
- frame_cnt  out  16  frames started since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - out_valid=0, out_pix=0, out_index=0, out_hs=1, out_vs=1, frame_cnt=0.
  - Latched mode=0, latched alpha=0, both stage valids=0.
  - in_ready is 1 whenever both stages are empty, including during reset.
- Acceptance: a beat is accepted when in_valid && in_ready at a rising clk edge.
- Pipeline:
  - Two register stages. S1 captures the inputs; S2 computes and holds the outputs.
  - Latency with out_ready held high: 2 cycles from acceptance to out_valid.
  - Throughput: 1 beat per cycle.
- Flow control:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when S1 is valid and S2 advances.
  - in_ready = !S1_valid || S1_advance (combinational).
  - Beats are never dropped or duplicated, and order is preserved.
  - While out_valid && !out_ready, all out_* signals stay stable.
- Mode and alpha latching:
  - mode and alpha are latched only on an accepted beat with in_index==0, and apply from that beat onward.
  - A change mid-frame takes effect at the next frame.
- Frame counter: frame_cnt increments on each accepted beat with in_index==0 and wraps from 0xFFFF to 0.
- Modes, applied per channel (i = image channel, w = watermark channel, M = 2^CH_W-1):
  - 0: image_pix
  - 1: water_pix
  - 2: regout_pix
  - 3: image_pix ^ water_pix
  - 4: alpha blend, (i*(2^ALPHA_W-alpha) + w*alpha) >> ALPHA_W, with intermediate width CH_W+ALPHA_W+1, truncated
  - 5: LSB embed, {i[CH_W-1:1], w[CH_W-1]}
  - 6: saturating add, min(i+w, M)
  - 7: reserved; behaves as mode 0
- Source sampling: all three sources are sampled at acceptance; the compositing function uses S1 contents.
- Reset mid-operation: in-flight beats are discarded, the latched mode returns to 0, and the first beat after reset uses mode 0 until an index-0 beat is accepted.

Optional Feature:
- Macro: WM_SAT_COUNT_EN.
- Defined:
  - Adds output port sat_cnt [15:0], reset 0.
  - Increments once per beat leaving S2 (out_valid && out_ready) in mode 6 where any channel clamped.
  - Wraps from 0xFFFF to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_hs=out_vs=1, frame_cnt=0, in_ready=1. Release, then accept an index-0 beat in mode 1 with water_pix=0x123 -> out_pix=0x123 two cycles later.
- Alpha blend: mode=4, alpha=8, image=0xF00, water=0x0F0, index 0 -> out_pix=0x770. With alpha=0 -> 0xF00.
- LSB embed and saturating add:
  - mode=5, image=0x888, water=0x80F -> 0x989.
  - mode=6, image=0x9A3, water=0x805 -> 0xFA8, and sat_cnt increments by 1 when WM_SAT_COUNT_EN is defined.
- Backpressure:
  - Stream 6 beats with in_valid=1 and out_ready=0 for 4 cycles -> in_ready deasserts after 2 accepted beats and out_pix stays stable.
  - Raise out_ready -> all 6 beats emerge in order, none lost.
- Mode latching:
  - Frame in mode 0; switch mode to 1 at index 5 -> indices 5..N still use image_pix.
  - Next index-0 beat outputs water_pix, and frame_cnt goes from 1 to 2.
- Async reset mid-stream: assert rst_n low between clock edges with 2 beats in flight -> out_valid falls immediately and neither beat ever appears. Force frame_cnt to 0xFFFF via 65535 index-0 beats, then one more -> frame_cnt = 0.
